// File: rtl/od_datapath.sv
`default_nettype none
// ============================================================================
// Module   : od_datapath
// Brief    : Multi-cycle RV32I integer datapath (PC, IR, register file,
//            A/B/F latches, ALU) driven by external control-unit strobes.
// Revision : 1.0
// ============================================================================
module od_datapath #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_rdata,
    input  logic        PC_Write,
    input  logic        IR_Write,
    input  logic        Reg_Write,
    input  logic        rs2_imm_s,
    input  logic        w_data_s,
    input  logic [3:0]  ALU_OP,
    output logic [6:0]  opcode,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    output logic [31:0] alu_f,
    output logic [3:0]  flags
);

    localparam logic [3:0] c_ALU_ADD  = 4'b0000;
    localparam logic [3:0] c_ALU_SUB  = 4'b1000;
    localparam logic [3:0] c_ALU_SLL  = 4'b0001;
    localparam logic [3:0] c_ALU_SLT  = 4'b0010;
    localparam logic [3:0] c_ALU_SLTU = 4'b0011;
    localparam logic [3:0] c_ALU_XOR  = 4'b0100;
    localparam logic [3:0] c_ALU_SRL  = 4'b0101;
    localparam logic [3:0] c_ALU_SRA  = 4'b1101;
    localparam logic [3:0] c_ALU_OR   = 4'b0110;
    localparam logic [3:0] c_ALU_AND  = 4'b0111;
    localparam logic [31:0] c_PC_STEP = 32'(PC_STEP);

    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_f;
    logic [3:0]  r_flags;
    logic [31:0] r_regs [32];

    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_u;
    logic [31:0] w_x;
    logic [31:0] w_y;
    logic [32:0] w_sum;
    logic [32:0] w_diff;
    logic [31:0] w_res;
    logic        w_cf;
    logic        w_of;
    logic [31:0] w_wb_data;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;

    assign w_rs1   = r_ir[19:15];
    assign w_rs2   = r_ir[24:20];
    assign w_rd    = r_ir[11:7];
    assign w_imm_i = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_u = {r_ir[31:12], 12'b0};

    assign inst_addr = r_pc;
    assign opcode    = r_ir[6:0];
    assign funct3    = r_ir[14:12];
    assign funct7    = r_ir[31:25];
    assign alu_f     = r_f;
    assign flags     = r_flags;

    // x0 is forced to zero on read so it never depends on storage contents
    assign w_rs1_val = (w_rs1 == 5'd0) ? 32'h0 : r_regs[w_rs1];
    assign w_rs2_val = (w_rs2 == 5'd0) ? 32'h0 : r_regs[w_rs2];

    assign w_x    = r_a;
    assign w_y    = rs2_imm_s ? w_imm_i : r_b;
    assign w_sum  = {1'b0, w_x} + {1'b0, w_y};
    assign w_diff = {1'b0, w_x} - {1'b0, w_y};

    assign w_wb_data = w_data_s ? w_imm_u : r_f;

    always_comb begin
        w_res = w_sum[31:0];
        w_cf  = w_sum[32];
        w_of  = (w_x[31] == w_y[31]) && (w_sum[31] != w_x[31]);
        case (ALU_OP)
            c_ALU_ADD: ;
            c_ALU_SUB: begin
                // bit 32 of the 33-bit difference is the unsigned borrow
                w_res = w_diff[31:0];
                w_cf  = w_diff[32];
                w_of  = (w_x[31] != w_y[31]) && (w_diff[31] != w_x[31]);
            end
            c_ALU_SLL: begin
                w_res = w_x << w_y[4:0];
                w_cf  = 1'b0;
                w_of  = 1'b0;
            end
            c_ALU_SLT: begin
                w_res = {31'b0, ($signed(w_x) < $signed(w_y))};
                w_cf  = 1'b0;
                w_of  = 1'b0;
            end
            c_ALU_SLTU: begin
                w_res = {31'b0, (w_x < w_y)};
                w_cf  = 1'b0;
                w_of  = 1'b0;
            end
            c_ALU_XOR: begin
                w_res = w_x ^ w_y;
                w_cf  = 1'b0;
                w_of  = 1'b0;
            end
            c_ALU_SRL: begin
                w_res = w_x >> w_y[4:0];
                w_cf  = 1'b0;
                w_of  = 1'b0;
            end
            c_ALU_SRA: begin
                w_res = $unsigned($signed(w_x) >>> w_y[4:0]);
                w_cf  = 1'b0;
                w_of  = 1'b0;
            end
            c_ALU_OR: begin
                w_res = w_x | w_y;
                w_cf  = 1'b0;
                w_of  = 1'b0;
            end
            c_ALU_AND: begin
                w_res = w_x & w_y;
                w_cf  = 1'b0;
                w_of  = 1'b0;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= RESET_PC;
            r_ir    <= 32'h0;
            r_a     <= 32'h0;
            r_b     <= 32'h0;
            r_f     <= 32'h0;
            r_flags <= 4'h0;
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= 32'h0;
            end
        end else begin
            if (PC_Write) begin
                r_pc <= r_pc + c_PC_STEP;
            end
            if (IR_Write) begin
                r_ir <= inst_rdata;
            end
            // A/B sample the pre-edge register file, giving read-before-write
            r_a     <= w_rs1_val;
            r_b     <= w_rs2_val;
            r_f     <= w_res;
            r_flags <= {(w_res == 32'h0), w_res[31], w_cf, w_of};
            if (Reg_Write && (w_rd != 5'd0)) begin
                r_regs[w_rd] <= w_wb_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_od_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_od_datapath
// Brief    : Self-checking bench for od_datapath: directed sequences, an ALU
//            vector table and randomized strobes against a reference model.
// Revision : 1.0
// ============================================================================
module tb_od_datapath;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata = '0;
    logic        pc_write = 1'b0, ir_write = 1'b0, reg_write = 1'b0;
    logic        rs2_imm_s = 1'b0, w_data_s = 1'b0;
    logic [3:0]  alu_op = '0;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [31:0] alu_f;
    logic [3:0]  flags;

    logic        pcw2 = 1'b0;
    logic [31:0] addr2, f2;
    logic [6:0]  op2, f7_2;
    logic [2:0]  f3_2;
    logic [3:0]  fl2;

    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    od_datapath u_dut (
        .clk(clk), .rst(rst), .inst_addr(inst_addr), .inst_rdata(inst_rdata),
        .PC_Write(pc_write), .IR_Write(ir_write), .Reg_Write(reg_write),
        .rs2_imm_s(rs2_imm_s), .w_data_s(w_data_s), .ALU_OP(alu_op),
        .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .alu_f(alu_f), .flags(flags)
    );

    od_datapath #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) u_wrap (
        .clk(clk), .rst(rst), .inst_addr(addr2), .inst_rdata(32'h0),
        .PC_Write(pcw2), .IR_Write(1'b0), .Reg_Write(1'b0),
        .rs2_imm_s(1'b0), .w_data_s(1'b0), .ALU_OP(4'b0000),
        .opcode(op2), .funct3(f3_2), .funct7(f7_2),
        .alu_f(f2), .flags(fl2)
    );

    // ---------------- reference model ----------------
    localparam longint c_SMAX = 64'sh0000_0000_7FFF_FFFF;
    localparam longint c_SMIN = -64'sh0000_0000_8000_0000;

    function automatic void ref_alu(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                                    output logic [31:0] f, output logic [3:0] fl);
        logic   c, o;
        longint us, ss;
        c = 1'b0;
        o = 1'b0;
        case (op)
            4'b1000: begin
                f  = x - y;
                c  = (x < y);
                ss = longint'($signed(x)) - longint'($signed(y));
                o  = (ss > c_SMAX) || (ss < c_SMIN);
            end
            4'b0001: f = x << y[4:0];
            4'b0010: f = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            4'b0011: f = (x < y) ? 32'd1 : 32'd0;
            4'b0100: f = x ^ y;
            4'b0101: f = x >> y[4:0];
            4'b1101: f = $unsigned($signed(x) >>> y[4:0]);
            4'b0110: f = x | y;
            4'b0111: f = x & y;
            default: begin
                us = longint'(x) + longint'(y);
                f  = us[31:0];
                c  = (us > 64'sh0000_0000_FFFF_FFFF);
                ss = longint'($signed(x)) + longint'($signed(y));
                o  = (ss > c_SMAX) || (ss < c_SMIN);
            end
        endcase
        fl = {(f == 32'h0), f[31], c, o};
    endfunction

    logic [31:0] m_pc, m_ir, m_a, m_b, m_f;
    logic [3:0]  m_fl;
    logic [31:0] m_regs [32];
    logic [31:0] m_na, m_nb, m_y, m_nf;
    logic [3:0]  m_nfl;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_pc = 32'h0; m_ir = 32'h0; m_a = 32'h0; m_b = 32'h0; m_f = 32'h0; m_fl = 4'h0;
            for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        end else begin
            m_na = m_regs[m_ir[19:15]];
            m_nb = m_regs[m_ir[24:20]];
            m_y  = rs2_imm_s ? {{20{m_ir[31]}}, m_ir[31:20]} : m_b;
            ref_alu(alu_op, m_a, m_y, m_nf, m_nfl);
            if (reg_write && m_ir[11:7] != 5'd0)
                m_regs[m_ir[11:7]] = w_data_s ? {m_ir[31:12], 12'h000} : m_f;
            m_a = m_na; m_b = m_nb; m_f = m_nf; m_fl = m_nfl;
            if (ir_write) m_ir = inst_rdata;
            if (pc_write) m_pc = m_pc + 32'd4;
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic pcw, input logic irw, input logic rw, input logic rs,
                       input logic wd, input logic [3:0] op, input logic [31:0] ins);
        @(negedge clk);
        pc_write = pcw; ir_write = irw; reg_write = rw;
        rs2_imm_s = rs; w_data_s = wd; alu_op = op; inst_rdata = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic load_reg(input logic [4:0] r, input logic [31:0] v);
        logic [31:0] hi, lo;
        hi = (v + 32'h800) >> 12;
        lo = v - (hi << 12);
        cyc(0, 1, 0, 0, 0, 4'h0, {hi[19:0], r, 7'h37});
        cyc(0, 0, 1, 0, 1, 4'h0, 32'h0);
        cyc(0, 1, 0, 0, 0, 4'h0, {lo[11:0], r, 3'b000, r, 7'h13});
        cyc(0, 0, 0, 0, 0, 4'h0, 32'h0);
        cyc(0, 0, 0, 1, 0, 4'h0, 32'h0);
        cyc(0, 0, 1, 0, 0, 4'h0, 32'h0);
    endtask

    task automatic read_reg(input logic [4:0] r, output logic [31:0] v);
        cyc(0, 1, 0, 0, 0, 4'h0, {12'h000, r, 3'b000, 5'd0, 7'h13});
        cyc(0, 0, 0, 0, 0, 4'h0, 32'h0);
        cyc(0, 0, 0, 1, 0, 4'h0, 32'h0);
        v = alu_f;
    endtask

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] x;
        logic [31:0] y;
        logic [31:0] f;
        logic [3:0]  fl;
    } vec_t;

    vec_t        tbl [15];
    logic [31:0] rv;

    initial begin
        tbl[0]  = '{4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 4'b0101};
        tbl[1]  = '{4'b1101, 32'h8000_0000, 32'h0000_0004, 32'hF800_0000, 4'b0100};
        tbl[2]  = '{4'b1000, 32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 4'b0110};
        tbl[3]  = '{4'b0000, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b1010};
        tbl[4]  = '{4'b1000, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 4'b0001};
        tbl[5]  = '{4'b0010, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 4'b0000};
        tbl[6]  = '{4'b0011, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000, 4'b1000};
        tbl[7]  = '{4'b0001, 32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 4'b0100};
        tbl[8]  = '{4'b0101, 32'h8000_0000, 32'h0000_001F, 32'h0000_0001, 4'b0000};
        tbl[9]  = '{4'b0100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 4'b0000};
        tbl[10] = '{4'b0110, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 4'b0000};
        tbl[11] = '{4'b0111, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 4'b0000};
        tbl[12] = '{4'b1111, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 4'b0000};
        tbl[13] = '{4'b1000, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 4'b1000};
        tbl[14] = '{4'b0001, 32'h0000_0001, 32'h0000_0021, 32'h0000_0002, 4'b0000};

        // power-on reset
        repeat (2) @(posedge clk);
        #1;
        check("reset pc", inst_addr, 32'h0);
        check("reset opcode", {25'h0, opcode}, 32'h0);
        check("reset f", alu_f, 32'h0);
        check("reset flags", {28'h0, flags}, 32'h0);
        check("wrap reset pc", addr2, 32'hFFFF_FFFC);
        @(negedge clk);
        rst = 1'b1;

        // ADDI x1,x0,5
        cyc(1, 1, 0, 0, 0, 4'h0, 32'h0050_0093);
        check("addi pc", inst_addr, 32'h4);
        check("addi opcode", {25'h0, opcode}, 32'h13);
        cyc(0, 0, 0, 0, 0, 4'h0, 32'h0);
        cyc(0, 0, 0, 1, 0, 4'h0, 32'h0);
        check("addi f", alu_f, 32'h5);
        cyc(0, 0, 1, 0, 0, 4'h0, 32'h0);
        read_reg(5'd1, rv);
        check("x1", rv, 32'h5);

        // ADDI x2,x0,7 then SUB x3,x1,x2
        cyc(1, 1, 0, 0, 0, 4'h0, 32'h0070_0113);
        cyc(0, 0, 0, 0, 0, 4'h0, 32'h0);
        cyc(0, 0, 0, 1, 0, 4'h0, 32'h0);
        cyc(0, 0, 1, 0, 0, 4'h0, 32'h0);
        cyc(1, 1, 0, 0, 0, 4'h0, 32'h4020_81B3);
        check("sub funct7", {25'h0, funct7}, 32'h20);
        check("sub pc", inst_addr, 32'hC);
        cyc(0, 0, 0, 0, 0, 4'h0, 32'h0);
        cyc(0, 0, 0, 0, 0, 4'b1000, 32'h0);
        check("sub f", alu_f, 32'hFFFF_FFFE);
        check("sub flags", {28'h0, flags}, 32'h6);
        cyc(0, 0, 1, 0, 0, 4'h0, 32'h0);
        read_reg(5'd3, rv);
        check("x3", rv, 32'hFFFF_FFFE);

        // LUI x4 and LUI x0
        cyc(1, 1, 0, 0, 0, 4'h0, 32'h1234_5237);
        cyc(0, 0, 1, 0, 1, 4'h0, 32'h0);
        read_reg(5'd4, rv);
        check("x4 lui", rv, 32'h1234_5000);
        cyc(1, 1, 0, 0, 0, 4'h0, 32'h1234_5037);
        cyc(0, 0, 1, 0, 1, 4'h0, 32'h0);
        read_reg(5'd0, rv);
        check("x0 lui", rv, 32'h0);

        // same-edge write and read of x5: A must capture the old value
        load_reg(5'd5, 32'd11);
        cyc(0, 1, 0, 0, 0, 4'h0, 32'h0012_8293);
        cyc(0, 0, 0, 0, 0, 4'h0, 32'h0);
        cyc(0, 0, 0, 1, 0, 4'h0, 32'h0);
        cyc(0, 0, 1, 1, 0, 4'h0, 32'h0);
        cyc(0, 0, 0, 1, 0, 4'h0, 32'h0);
        check("rbw a old", alu_f, 32'd12);
        read_reg(5'd5, rv);
        check("x5 written", rv, 32'd12);

        // ALU vector table
        for (int i = 0; i < 15; i++) begin
            load_reg(5'd1, tbl[i].x);
            load_reg(5'd2, tbl[i].y);
            cyc(0, 1, 0, 0, 0, 4'h0, 32'h0020_81B3);
            cyc(0, 0, 0, 0, 0, 4'h0, 32'h0);
            cyc(0, 0, 0, 0, 0, tbl[i].op, 32'h0);
            check($sformatf("alu[%0d] f", i), alu_f, tbl[i].f);
            check($sformatf("alu[%0d] flags", i), {28'h0, flags}, {28'h0, tbl[i].fl});
        end

        // PC wrap on the second instance, then hold
        @(negedge clk);
        pcw2 = 1'b1;
        @(posedge clk);
        #1;
        pcw2 = 1'b0;
        check("pc wrap", addr2, 32'h0);
        @(posedge clk);
        #1;
        check("pc hold", addr2, 32'h0);

        // asynchronous reset mid-instruction
        cyc(1, 1, 0, 0, 0, 4'h0, 32'h0050_0093);
        @(negedge clk);
        pc_write = 1'b0; ir_write = 1'b0; reg_write = 1'b0;
        rs2_imm_s = 1'b0; w_data_s = 1'b0; alu_op = 4'h0;
        #2;
        rst = 1'b0;
        #1;
        check("mid reset pc", inst_addr, 32'h0);
        check("mid reset opcode", {25'h0, opcode}, 32'h0);
        check("mid reset flags", {28'h0, flags}, 32'h0);
        check("mid reset f", alu_f, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        for (int r = 1; r < 32; r++) begin
            read_reg(5'(r), rv);
            check($sformatf("x%0d after reset", r), rv, 32'h0);
        end

        // randomized strobes against the reference model
        for (int n = 0; n < 400; n++) begin
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                4'($urandom), $urandom);
            check("rand pc", inst_addr, m_pc);
            check("rand ir", {15'h0, funct7, funct3, opcode},
                  {15'h0, m_ir[31:25], m_ir[14:12], m_ir[6:0]});
            check("rand f", alu_f, m_f);
            check("rand flags", {28'h0, flags}, {28'h0, m_fl});
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
`default_nettype wire
